dacx0504_spi_responder: RTL and testbench
=========================================

DACX0504_SPI_RESPONDER -- requirements
Module: dacx0504_spi_responder

Interface
REQ-001 SHALL have parameter DEVICE_ID, default 16'h0A14, value returned on reads of address 4'h1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (minimum 2).
REQ-003 OPB_CLK  in  1  system clock; all logic on its rising edge.
REQ-004 OPB_RST  in  1  reset, asynchronous, active-high.
REQ-005 DAC_CLK  in  1  SPI serial clock from controller, asynchronous to OPB_CLK.
REQ-006 DAC_CS_N  in  1  frame select, active-low.
REQ-007 DAC_SDI  in  1  serial data from controller, MSB first.
REQ-008 DAC_SDO  out  1  serial readback data, MSB first.
REQ-009 DAC0_OUT..DAC3_OUT  out  16 each  active DAC codes.
REQ-010 GAIN_REG, CONFIG_REG  out  16 each  current register contents.
REQ-011 FRAME_DONE  out  1  one-cycle pulse per committed 24-bit frame.
REQ-012 FRAME_ERR  out  1  one-cycle pulse per aborted frame (bit count not 24).

Function
REQ-013 Frame format SHALL be bit23 RW (1 = read), bits22:20 ignored, bits19:16 address, bits15:0 data.
REQ-014 DAC_CLK, DAC_CS_N and DAC_SDI SHALL pass through SYNC_STAGES flops before use; edges are detected on synchronized signals only.
REQ-015 DAC_CLK frequency SHALL be at most OPB_CLK/4; faster clocks are unsupported.
REQ-016 State machine SHALL have states IDLE, SHIFT, COMMIT.
REQ-017 IDLE -> SHIFT on synchronized DAC_CS_N falling edge; bit counter cleared and shift-out register loaded from the readback latch in the same cycle.
REQ-018 In SHIFT, each synchronized DAC_CLK falling edge SHALL shift the synchronized DAC_SDI into the shift-in register LSB and increment the counter, which saturates at 25.
REQ-019 In SHIFT, each synchronized DAC_CLK rising edge SHALL advance the shift-out register by one bit. DAC_SDO = shift-out MSB while DAC_CS_N is low, else 0.
REQ-020 SHIFT -> COMMIT on synchronized DAC_CS_N rising edge when the counter = 24; SHIFT -> IDLE with a FRAME_ERR pulse and no register change when the counter is not 24.
REQ-021 COMMIT SHALL last exactly one cycle: apply the write or read, pulse FRAME_DONE, then go to IDLE.
REQ-022 Read frame: readback latch <= {1'b1, 3'b000, A, register[A]}; no register changes. Write frame: readback latch <= 24'h0.
REQ-023 The readback latch SHALL be shifted out during the next frame, regardless of that frame's content (one-frame read latency).
REQ-024 Register map: 0 NOP (write ignored, reads 0); 1 DEVICE_ID (read-only); 2 SYNC (bits3:0 per-channel sync enable, reset 0); 3 CONFIG (reset 0); 4 GAIN (reset 0); 5 TRIGGER (write-only, reads 0); 6 BRDCAST (reset 0); 7 STATUS (reads 0); 8-B DAC0-3 buffer (reset 0); C-F unmapped (write ignored, reads 0).
REQ-025 Write to DACn buffer: if SYNC[n]=0, DACn_OUT updates in the same COMMIT cycle; if SYNC[n]=1, only the buffer updates.
REQ-026 Write to BRDCAST SHALL store the data in BRDCAST and load it into all four buffers, with per-channel output update as in REQ-025.
REQ-027 Write to TRIGGER with data[4]=1 (LDAC) SHALL copy every buffer with SYNC[n]=1 to DACn_OUT.
REQ-028 Write to TRIGGER with data[3:0]=4'hA SHALL soft-reset all registers, buffers, outputs and the readback latch to reset values; soft reset takes precedence over LDAC in the same write.
REQ-029 Reads of DACn return the buffer value, not DACn_OUT.
REQ-030 DAC_CS_N deasserted with no DAC_CLK edges (counter 0) SHALL produce FRAME_ERR only.

Reset
REQ-031 On OPB_RST: state IDLE; counter, shift registers and readback latch 0; all registers at reset values; DACn_OUT=0; DAC_SDO=0; FRAME_DONE=0; FRAME_ERR=0; synchronizers preset to DAC_CS_N=1, DAC_CLK=0, DAC_SDI=0.
REQ-032 OPB_RST asserted mid-frame SHALL abandon the frame. After release, the remainder of that frame is ignored until a new DAC_CS_N falling edge is seen.

Verification
REQ-033 Write 24'h08_1234 (DAC0, SYNC=0) -> DAC0_OUT=16'h1234 one cycle after FRAME_DONE; DAC_SDO all 0 during the frame.
REQ-034 Read 24'h81_0000, then NOP 24'h00_0000 -> second frame DAC_SDO returns 24'h81_0A14; first frame returns 24'h0.
REQ-035 SYNC write 24'h02_0003, write DAC1=16'hBEEF -> DAC1_OUT unchanged; TRIGGER 24'h05_0010 -> DAC1_OUT=16'hBEEF.
REQ-036 BRDCAST 24'h06_5555 with SYNC=0 -> all DACn_OUT=16'h5555; TRIGGER 24'h05_000A -> all outputs 0 and SYNC=0.
REQ-037 20-bit frame writing DAC2 -> FRAME_ERR pulse, DAC2_OUT and buffer unchanged, no FRAME_DONE.
REQ-038 OPB_RST mid-frame during a DAC3 write -> DAC3_OUT=0 after reset; the next full frame commits correctly.

Source files
------------

// File: rtl/dacx0504_spi_responder.sv
// SPI responder for a DACx0504-style quad DAC register map: 24-bit frames are
// shifted in on DAC_CLK, then committed to buffered DAC registers in the OPB_CLK domain.
module dacx0504_spi_responder #(
  parameter logic [15:0] DEVICE_ID   = 16'h0A14,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        DAC_CLK,
  input  logic        DAC_CS_N,
  input  logic        DAC_SDI,
  output logic        DAC_SDO,
  output logic [15:0] DAC0_OUT,
  output logic [15:0] DAC1_OUT,
  output logic [15:0] DAC2_OUT,
  output logic [15:0] DAC3_OUT,
  output logic [15:0] GAIN_REG,
  output logic [15:0] CONFIG_REG,
  output logic        FRAME_DONE,
  output logic        FRAME_ERR
);

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CNT_SAT    = FRAME_BITS + 1;
  localparam int unsigned ARM_MAX    = SYNC_STAGES + 1;
  localparam int unsigned ARM_W      = $clog2(ARM_MAX + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state, state_d;
  logic [SYNC_STAGES-1:0]  clk_sync, cs_sync, sdi_sync;
  logic                    clk_s, cs_s, sdi_s, clk_prev, cs_prev;
  logic                    clk_fall, clk_rise, cs_fall, cs_rise;
  logic [ARM_W-1:0]        arm_cnt;
  logic                    armed;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [FRAME_BITS-1:0]   sin, sin_d, sout, sout_d, rb_latch;
  logic                    sdo_d, done_d, err_d;

  logic                    rw;
  logic [3:0]              addr;
  logic [15:0]             data, rd_data;
  logic [2:0]              frame_unused;

  logic [3:0]              sync_reg;
  logic [15:0]             config_reg, gain_reg, brdcast_reg;
  logic [15:0]             dac_buf [4];
  logic [15:0]             dac_out [4];

  // Input synchronizers, preset to the idle bus levels
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      clk_sync <= '0;
      cs_sync  <= '1;
      sdi_sync <= '0;
      clk_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], DAC_CLK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], DAC_CS_N};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], DAC_SDI};
      clk_prev <= clk_s;
      cs_prev  <= cs_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign clk_fall = clk_prev & ~clk_s;
  assign clk_rise = ~clk_prev & clk_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign cs_fall  = armed & cs_prev & ~cs_s;

  // Frame start is only accepted once CS has been genuinely high after reset,
  // so a frame interrupted by reset is not picked up halfway through.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      arm_cnt <= '0;
    end else if (!cs_s) begin
      arm_cnt <= '0;
    end else if (arm_cnt != ARM_W'(ARM_MAX)) begin
      arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  assign armed = (arm_cnt == ARM_W'(ARM_MAX));

  // Frame state and shift registers
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state      <= IDLE;
      cnt        <= '0;
      sin        <= '0;
      sout       <= '0;
      DAC_SDO    <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sin        <= sin_d;
      sout       <= sout_d;
      DAC_SDO    <= sdo_d;
      FRAME_DONE <= done_d;
      FRAME_ERR  <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sin_d   = sin;
    sout_d  = sout;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sin_d   = '0;
          sout_d  = rb_latch;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (cnt == CNT_W'(FRAME_BITS)) begin
            state_d = COMMIT;
            done_d  = 1'b1;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else begin
          if (clk_fall) begin
            sin_d = {sin[FRAME_BITS-2:0], sdi_s};
            if (cnt != CNT_W'(CNT_SAT)) cnt_d = cnt + CNT_W'(1);
          end
          if (clk_rise) sout_d = {sout[FRAME_BITS-2:0], 1'b0};
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sdo_d = (state_d == SHIFT) ? sout_d[FRAME_BITS-1] : 1'b0;
  end

  assign rw           = sin[23];
  assign frame_unused = sin[22:20];
  assign addr         = sin[19:16];
  assign data         = sin[15:0];

  // Readback mux; DAC addresses return the buffer, not the active output
  always_comb begin
    rd_data = '0;
    case (addr)
      4'h1:                      rd_data = DEVICE_ID;
      4'h2:                      rd_data = {12'h000, sync_reg};
      4'h3:                      rd_data = config_reg;
      4'h4:                      rd_data = gain_reg;
      4'h6:                      rd_data = brdcast_reg;
      4'h8, 4'h9, 4'hA, 4'hB:    rd_data = dac_buf[addr[1:0]];
      default:                   rd_data = '0;
    endcase
  end

  // Register file, applied in the single COMMIT cycle
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      rb_latch    <= '0;
      sync_reg    <= '0;
      config_reg  <= '0;
      gain_reg    <= '0;
      brdcast_reg <= '0;
      for (int n = 0; n < 4; n++) begin
        dac_buf[n] <= '0;
        dac_out[n] <= '0;
      end
    end else if (state == COMMIT) begin
      if (rw) begin
        rb_latch <= {1'b1, 3'b000, addr, rd_data};
      end else begin
        rb_latch <= '0;
        case (addr)
          4'h2: sync_reg   <= data[3:0];
          4'h3: config_reg <= data;
          4'h4: gain_reg   <= data;
          4'h5: begin
            if (data[3:0] == 4'hA) begin
              sync_reg    <= '0;
              config_reg  <= '0;
              gain_reg    <= '0;
              brdcast_reg <= '0;
              for (int n = 0; n < 4; n++) begin
                dac_buf[n] <= '0;
                dac_out[n] <= '0;
              end
            end else if (data[4]) begin
              for (int n = 0; n < 4; n++) begin
                if (sync_reg[n]) dac_out[n] <= dac_buf[n];
              end
            end
          end
          4'h6: begin
            brdcast_reg <= data;
            for (int n = 0; n < 4; n++) begin
              dac_buf[n] <= data;
              if (!sync_reg[n]) dac_out[n] <= data;
            end
          end
          4'h8, 4'h9, 4'hA, 4'hB: begin
            dac_buf[addr[1:0]] <= data;
            if (!sync_reg[addr[1:0]]) dac_out[addr[1:0]] <= data;
          end
          default: ;
        endcase
      end
    end
  end

  assign DAC0_OUT   = dac_out[0];
  assign DAC1_OUT   = dac_out[1];
  assign DAC2_OUT   = dac_out[2];
  assign DAC3_OUT   = dac_out[3];
  assign GAIN_REG   = gain_reg;
  assign CONFIG_REG = config_reg;

endmodule

// File: tb/tb_dacx0504_spi_responder.sv
// Bench for dacx0504_spi_responder: table of SPI frames with expected register
// state, readback words checked through a scoreboard queue, plus reset corner cases.
module tb_dacx0504_spi_responder;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST;
  logic        DAC_CLK, DAC_CS_N, DAC_SDI;
  logic        DAC_SDO;
  logic [15:0] DAC0_OUT, DAC1_OUT, DAC2_OUT, DAC3_OUT, GAIN_REG, CONFIG_REG;
  logic        FRAME_DONE, FRAME_ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic done_prev = 1'b0;
  logic [15:0] dac0_at_done    = 16'hxxxx;
  logic [15:0] dac0_after_done = 16'hxxxx;

  logic [23:0] sb_q[$];

  typedef struct {
    logic [23:0] frame;
    int          nbits;
    logic [23:0] sdo;
    logic        done;
    logic [15:0] d0, d1, d2, d3, gain, cfg;
  } vec_t;

  vec_t vecs[$];

  dacx0504_spi_responder #(.DEVICE_ID(16'h0A14), .SYNC_STAGES(2)) dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST),
    .DAC_CLK(DAC_CLK), .DAC_CS_N(DAC_CS_N), .DAC_SDI(DAC_SDI), .DAC_SDO(DAC_SDO),
    .DAC0_OUT(DAC0_OUT), .DAC1_OUT(DAC1_OUT), .DAC2_OUT(DAC2_OUT), .DAC3_OUT(DAC3_OUT),
    .GAIN_REG(GAIN_REG), .CONFIG_REG(CONFIG_REG),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  // Pulse counters (count high cycles, so a stretched pulse shows up too)
  always @(negedge OPB_CLK) begin
    if (done_prev) dac0_after_done = DAC0_OUT;
    if (FRAME_DONE) begin
      done_cnt++;
      dac0_at_done = DAC0_OUT;
    end
    if (FRAME_ERR) err_cnt++;
    done_prev = FRAME_DONE;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge OPB_CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // DAC_CLK idles high: SDI set up, SDO sampled, then falling edge, then rising edge
  task automatic spi_bits(input logic [23:0] f, input int from, input int to,
                          inout logic [23:0] cap);
    logic [23:0] sh;
    sh = f << from;
    for (int i = from; i < to; i++) begin
      DAC_SDI = sh[23];
      sh = sh << 1;
      tick(4);
      if (i < 24) cap = {cap[22:0], DAC_SDO};
      DAC_CLK = 1'b0;
      tick(8);
      DAC_CLK = 1'b1;
      tick(4);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [23:0] cap, exp_s;
    int d0c, e0c, n;
    sb_q.push_back(v.sdo);
    d0c = done_cnt;
    e0c = err_cnt;
    cap = '0;
    DAC_CS_N = 1'b0;
    tick(8);
    spi_bits(v.frame, 0, v.nbits, cap);
    tick(4);
    DAC_CS_N = 1'b1;
    DAC_SDI  = 1'b0;
    tick(16);
    exp_s = sb_q.pop_front();
    n = (v.nbits > 24) ? 24 : v.nbits;
    if (n > 0) check($sformatf("v%0d_sdo", idx), 32'(cap), 32'(exp_s >> (24 - n)));
    check($sformatf("v%0d_done", idx), 32'(done_cnt - d0c), v.done ? 32'd1 : 32'd0);
    check($sformatf("v%0d_err", idx),  32'(err_cnt - e0c),  v.done ? 32'd0 : 32'd1);
    check($sformatf("v%0d_dac0", idx), 32'(DAC0_OUT), 32'(v.d0));
    check($sformatf("v%0d_dac1", idx), 32'(DAC1_OUT), 32'(v.d1));
    check($sformatf("v%0d_dac2", idx), 32'(DAC2_OUT), 32'(v.d2));
    check($sformatf("v%0d_dac3", idx), 32'(DAC3_OUT), 32'(v.d3));
    check($sformatf("v%0d_gain", idx), 32'(GAIN_REG), 32'(v.gain));
    check($sformatf("v%0d_cfg", idx),  32'(CONFIG_REG), 32'(v.cfg));
  endtask

  initial begin
    logic [23:0] cap;
    vec_t fin;
    int d0c, e0c;

    //                frame     nbits sdo        done  d0       d1       d2       d3       gain     cfg
    vecs.push_back('{24'h081234, 24, 24'h000000, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h810000, 24, 24'h000000, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h000000, 24, 24'h810A14, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h020003, 24, 24'h000000, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h09BEEF, 24, 24'h000000, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h890000, 24, 24'h000000, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h000000, 24, 24'h89BEEF, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h050010, 24, 24'h000000, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h0300C3, 24, 24'h000000, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h00C3});
    vecs.push_back('{24'h048001, 24, 24'h000000, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h820000, 24, 24'h000000, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h000000, 24, 24'h820003, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h065555, 24, 24'h000000, 1'b1, 16'h1234, 16'hBEEF, 16'h5555, 16'h5555, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h020000, 24, 24'h000000, 1'b1, 16'h1234, 16'hBEEF, 16'h5555, 16'h5555, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h065555, 24, 24'h000000, 1'b1, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h860000, 24, 24'h000000, 1'b1, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h000000, 24, 24'h865555, 1'b1, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h0A1111, 20, 24'h000000, 1'b0, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h8A0000, 24, 24'h000000, 1'b1, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h000000, 24, 24'h8A5555, 1'b1, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h840000, 24, 24'h000000, 1'b1, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h8001, 16'h00C3});
    vecs.push_back('{24'h05000A, 24, 24'h848001, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h820000, 24, 24'h000000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h000000, 24, 24'h820000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h000000,  0, 24'h000000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h0B7777, 24, 24'h000000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h7777, 16'h0000, 16'h0000});
    vecs.push_back('{24'h05001A, 24, 24'h000000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h8D0000, 24, 24'h000000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h0DFFFF, 24, 24'h8D0000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h092222, 26, 24'h000000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h890000, 24, 24'h000000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h000000, 24, 24'h890000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{24'h0B1111, 24, 24'h000000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 16'h0000, 16'h0000});

    OPB_RST  = 1'b1;
    DAC_CLK  = 1'b1;
    DAC_CS_N = 1'b1;
    DAC_SDI  = 1'b0;
    tick(3);
    check("rst_dac0", 32'(DAC0_OUT), 32'h0);
    check("rst_dac1", 32'(DAC1_OUT), 32'h0);
    check("rst_dac2", 32'(DAC2_OUT), 32'h0);
    check("rst_dac3", 32'(DAC3_OUT), 32'h0);
    check("rst_gain", 32'(GAIN_REG), 32'h0);
    check("rst_cfg",  32'(CONFIG_REG), 32'h0);
    check("rst_sdo",  32'(DAC_SDO), 32'h0);
    check("rst_done", 32'(FRAME_DONE), 32'h0);
    check("rst_err",  32'(FRAME_ERR), 32'h0);
    OPB_RST = 1'b0;
    tick(20);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
      if (i == 0) begin
        check("dac0_at_done",    32'(dac0_at_done),    32'h0000);
        check("dac0_after_done", 32'(dac0_after_done), 32'h1234);
      end
    end

    // Reset in the middle of a DAC3 write; the tail of that frame must be ignored
    d0c = done_cnt;
    e0c = err_cnt;
    cap = '0;
    DAC_CS_N = 1'b0;
    tick(8);
    spi_bits(24'h0B9999, 0, 10, cap);
    OPB_RST = 1'b1;
    tick(3);
    OPB_RST = 1'b0;
    tick(2);
    spi_bits(24'h0B9999, 10, 24, cap);
    tick(4);
    DAC_CS_N = 1'b1;
    DAC_SDI  = 1'b0;
    tick(16);
    check("midrst_dac3", 32'(DAC3_OUT), 32'h0);
    check("midrst_done", 32'(done_cnt - d0c), 32'd0);
    check("midrst_err",  32'(err_cnt - e0c),  32'd0);

    fin = '{24'h0B4321, 24, 24'h000000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h4321, 16'h0000, 16'h0000};
    run_vec(99, fin);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
